// File: rtl/csr_pkg.sv
// ============================================================================
// Module : csr_pkg
// Brief  : Machine-mode CSR addresses, op encodings, mstatus/mip bit indices
//          and interrupt cause codes shared by the CSR unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;

    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

endpackage

`default_nettype wire

// File: rtl/csr_counter.sv
// ============================================================================
// Module : csr_counter
// Brief  : W-bit free-running/enabled counter with independent 32-bit half
//          writes; a write to either half suppresses that cycle's increment.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module csr_counter #(
    parameter int W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    localparam int HI_W = (W > 32) ? W - 32 : 1;

    generate
        if (W > 32) begin : g_wide
            logic [31:0]     r_lo;
            logic [HI_W-1:0] r_hi;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lo <= '0;
                    r_hi <= '0;
                end else if (wr_lo) begin
                    r_lo <= wdata;
                end else if (wr_hi) begin
                    r_hi <= wdata[HI_W-1:0];
                end else if (inc) begin
                    {r_hi, r_lo} <= {r_hi, r_lo} + 1'b1;
                end
            end

            assign value = 64'({r_hi, r_lo});
        end else begin : g_narrow
            logic [W-1:0] r_cnt;

            // High-half writes have no storage but still cancel the increment.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (wr_lo) begin
                    r_cnt <= wdata[W-1:0];
                end else if (!wr_hi && inc) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign value = 64'(r_cnt);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/csr_unit.sv
// ============================================================================
// Module : csr_unit
// Brief  : Machine-mode CSR unit: Zicsr RMW ops, trap entry/mret stacking,
//          mcycle/minstret counters and prioritised interrupt reporting.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              COUNTER_W = 64,
    parameter logic [XLEN-1:0] HART_ID   = '0,
    parameter bit              SYNC_IRQ  = 1'b1,
    parameter logic [XLEN-1:0] MISA_VAL  = 32'h4000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            csr_src_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instr_retire,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_soft,
    output logic [XLEN-1:0] mtvec_out,
    output logic [XLEN-1:0] mepc_out,
    output logic            irq_pending,
    output logic [XLEN-1:0] irq_cause
);

    generate
        if (XLEN != 32 || COUNTER_W < 32 || COUNTER_W > 64) begin : g_bad_param
            $error("csr_unit: XLEN must be 32 and COUNTER_W in 32..64");
        end
    endgenerate

    csr_op_e         w_op;
    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic [2:0]      r_mie_en;          // {MEIE, MTIE, MSIE}
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [2:0]      w_irq_sync;        // {ext, timer, soft}
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mie;
    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_pend;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_wval;
    logic            w_impl;
    logic            w_ro;
    logic            w_wr_try;
    logic            w_we;
    logic [63:0]     w_cycle;
    logic [63:0]     w_instret;

    assign w_op = csr_op_e'(csr_op);

    generate
        if (SYNC_IRQ) begin : g_sync
            logic [2:0] r_sync1;
            logic [2:0] r_sync2;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= '0;
                    r_sync2 <= '0;
                end else begin
                    r_sync1 <= {irq_ext, irq_timer, irq_soft};
                    r_sync2 <= r_sync1;
                end
            end
            assign w_irq_sync = r_sync2;
        end else begin : g_direct
            assign w_irq_sync = {irq_ext, irq_timer, irq_soft};
        end
    endgenerate

    always_comb begin
        w_mstatus = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[MSTATUS_MIE]  = r_mstatus_mie;
        w_mstatus[MSTATUS_MPIE] = r_mstatus_mpie;
        w_mie = '0;
        w_mie[IRQ_MEI] = r_mie_en[2];
        w_mie[IRQ_MTI] = r_mie_en[1];
        w_mie[IRQ_MSI] = r_mie_en[0];
        w_mip = '0;
        w_mip[IRQ_MEI] = w_irq_sync[2];
        w_mip[IRQ_MTI] = w_irq_sync[1];
        w_mip[IRQ_MSI] = w_irq_sync[0];
    end

    always_comb begin
        w_impl = 1'b1;
        w_old  = '0;
        case (csr_addr)
            CSR_MSTATUS:               w_old = w_mstatus;
            CSR_MISA:                  w_old = MISA_VAL;
            CSR_MIE:                   w_old = w_mie;
            CSR_MTVEC:                 w_old = r_mtvec;
            CSR_MSCRATCH:              w_old = r_mscratch;
            CSR_MEPC:                  w_old = r_mepc;
            CSR_MCAUSE:                w_old = r_mcause;
            CSR_MTVAL:                 w_old = r_mtval;
            CSR_MIP:                   w_old = w_mip;
            CSR_MCYCLE, CSR_CYCLE:     w_old = w_cycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:   w_old = w_cycle[63:32];
            CSR_MINSTRET, CSR_INSTRET: w_old = w_instret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: w_old = w_instret[63:32];
            CSR_MHARTID:               w_old = HART_ID;
            default:                   w_impl = 1'b0;
        endcase
    end

    always_comb begin
        w_wval = csr_wdata;
        case (w_op)
            CSR_OP_RS: w_wval = w_old | csr_wdata;
            CSR_OP_RC: w_wval = w_old & ~csr_wdata;
            default:   w_wval = csr_wdata;
        endcase
    end

    assign w_ro        = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MISA);
    assign w_wr_try    = (w_op == CSR_OP_RW) ||
                         (((w_op == CSR_OP_RS) || (w_op == CSR_OP_RC)) && !csr_src_zero);
    assign csr_illegal = (w_op != CSR_OP_NONE) && (!w_impl || (w_wr_try && w_ro));
    assign csr_rdata   = ((w_op != CSR_OP_NONE) && w_impl) ? w_old : '0;
    assign w_we        = w_wr_try && w_impl && !w_ro && !trap_take && !mret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_en       <= '0;
            r_mtvec        <= '0;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
        end else if (trap_take) begin
            r_mepc         <= trap_pc & ~32'h3;
            r_mcause       <= trap_cause;
            r_mtval        <= trap_val;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    r_mstatus_mie  <= w_wval[MSTATUS_MIE];
                    r_mstatus_mpie <= w_wval[MSTATUS_MPIE];
                end
                CSR_MIE:      r_mie_en   <= {w_wval[IRQ_MEI], w_wval[IRQ_MTI], w_wval[IRQ_MSI]};
                // Reserved MODE encodings leave the previous MODE in place.
                CSR_MTVEC:    r_mtvec    <= {w_wval[XLEN-1:2], w_wval[1] ? r_mtvec[1:0] : w_wval[1:0]};
                CSR_MSCRATCH: r_mscratch <= w_wval;
                CSR_MEPC:     r_mepc     <= w_wval & ~32'h3;
                CSR_MCAUSE:   r_mcause   <= w_wval;
                CSR_MTVAL:    r_mtval    <= w_wval;
                default:      ;
            endcase
        end
    end

    csr_counter #(.W(COUNTER_W)) u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (w_we && (csr_addr == CSR_MCYCLE)),
        .wr_hi (w_we && (csr_addr == CSR_MCYCLEH)),
        .wdata (w_wval),
        .value (w_cycle)
    );

    csr_counter #(.W(COUNTER_W)) u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (instr_retire),
        .wr_lo (w_we && (csr_addr == CSR_MINSTRET)),
        .wr_hi (w_we && (csr_addr == CSR_MINSTRETH)),
        .wdata (w_wval),
        .value (w_instret)
    );

    assign w_pend      = w_mip & w_mie;
    assign irq_pending = r_mstatus_mie && (|w_pend);

    always_comb begin
        irq_cause = '0;
        if (w_pend[IRQ_MEI])      irq_cause = CAUSE_MEI;
        else if (w_pend[IRQ_MSI]) irq_cause = CAUSE_MSI;
        else if (w_pend[IRQ_MTI]) irq_cause = CAUSE_MTI;
    end

    assign mtvec_out = r_mtvec;
    assign mepc_out  = r_mepc;

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// ============================================================================
// Module : tb_csr_unit
// Brief  : Directed self-checking bench for csr_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_src_zero = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_retire = 1'b0;
    logic        trap_take = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_val = '0;
    logic        mret = 1'b0;
    logic        irq_ext = 1'b0;
    logic        irq_timer = 1'b0;
    logic        irq_soft = 1'b0;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        irq_pending;
    logic [31:0] irq_cause;

    int checks = 0;
    int errs   = 0;

    csr_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_addr     (csr_addr),
        .csr_op       (csr_op),
        .csr_wdata    (csr_wdata),
        .csr_src_zero (csr_src_zero),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .instr_retire (instr_retire),
        .trap_take    (trap_take),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_val     (trap_val),
        .mret         (mret),
        .irq_ext      (irq_ext),
        .irq_timer    (irq_timer),
        .irq_soft     (irq_soft),
        .mtvec_out    (mtvec_out),
        .mepc_out     (mepc_out),
        .irq_pending  (irq_pending),
        .irq_cause    (irq_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Side-effect-free read (CSRRS with x0), consumes one cycle
    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
        csr_addr = a; csr_op = 2'b10; csr_wdata = '0; csr_src_zero = 1'b1;
        #1;
        chk(tag, csr_rdata, e);
        tick();
        csr_op = 2'b00; csr_src_zero = 1'b0;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_addr = a; csr_op = op; csr_wdata = d; csr_src_zero = 1'b0;
        tick();
        csr_op = 2'b00;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rdata", csr_rdata, 32'h0);
        chk("rst_pending", {31'b0, irq_pending}, 32'h0);
        chk("rst_cause", irq_cause, 32'h0);
        chk("rst_illegal", {31'b0, csr_illegal}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        rd(12'h300, 32'h0000_1800, "mstatus_reset");
        rd(12'h301, 32'h4000_0100, "misa");
        rd(12'hF14, 32'h0, "mhartid");

        // Zicsr set/clear on mscratch
        wr(2'b01, 12'h340, 32'h0F0);
        csr_addr = 12'h340; csr_op = 2'b10; csr_wdata = 32'h00F; csr_src_zero = 1'b0;
        #1;
        chk("rs_old", csr_rdata, 32'h0F0);
        tick();
        csr_op = 2'b00;
        rd(12'h340, 32'h0FF, "rs_new");
        csr_addr = 12'h340; csr_op = 2'b11; csr_wdata = 32'hFF; csr_src_zero = 1'b1;
        #1;
        chk("rc_zero_old", csr_rdata, 32'h0FF);
        tick();
        csr_op = 2'b00; csr_src_zero = 1'b0;
        rd(12'h340, 32'h0FF, "rc_zero_nochg");

        // Illegal accesses
        csr_addr = 12'h7C0; csr_op = 2'b10; csr_src_zero = 1'b1;
        #1;
        chk("unimpl_illegal", {31'b0, csr_illegal}, 32'h1);
        chk("unimpl_rdata", csr_rdata, 32'h0);
        csr_addr = 12'h301; csr_op = 2'b01; csr_wdata = 32'h0; csr_src_zero = 1'b0;
        #1;
        chk("misa_wr_illegal", {31'b0, csr_illegal}, 32'h1);
        tick();
        csr_op = 2'b00;
        rd(12'h301, 32'h4000_0100, "misa_unchanged");
        csr_addr = 12'h344; csr_op = 2'b01; csr_wdata = 32'hFFFF_FFFF;
        #1;
        chk("mip_wr_legal", {31'b0, csr_illegal}, 32'h0);
        tick();
        csr_op = 2'b00;

        // mcycle carry into the high half
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        wr(2'b01, 12'hB80, 32'h0);
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_held");
        rd(12'hB80, 32'h1, "mcycleh_carry");
        rd(12'hB00, 32'h1, "mcycle_wrap");
        csr_addr = 12'hC00; csr_op = 2'b01; csr_wdata = 32'h5;
        #1;
        chk("cycle_wr_illegal", {31'b0, csr_illegal}, 32'h1);
        tick();
        csr_op = 2'b00;

        // minstret
        wr(2'b01, 12'hB02, 32'd10);
        instr_retire = 1'b1;
        tick(); tick(); tick();
        instr_retire = 1'b0;
        rd(12'hB02, 32'd13, "minstret");
        rd(12'hC02, 32'd13, "instret_shadow");

        // Trap entry wins over a same-cycle CSR write, then mret
        wr(2'b01, 12'h300, 32'h8);
        rd(12'h300, 32'h0000_1808, "mstatus_mie");
        trap_take = 1'b1; trap_pc = 32'h1002; trap_cause = 32'h2; trap_val = 32'hDEAD;
        csr_addr = 12'h341; csr_op = 2'b01; csr_wdata = 32'h5550;
        tick();
        trap_take = 1'b0; csr_op = 2'b00;
        chk("mepc_out", mepc_out, 32'h1000);
        rd(12'h341, 32'h1000, "trap_mepc");
        rd(12'h300, 32'h0000_1880, "trap_mstatus");
        rd(12'h342, 32'h2, "trap_mcause");
        rd(12'h343, 32'hDEAD, "trap_mtval");
        mret = 1'b1;
        tick();
        mret = 1'b0;
        rd(12'h300, 32'h0000_1888, "mret_mstatus");

        // Interrupts
        wr(2'b01, 12'h304, 32'hFFFF);
        rd(12'h304, 32'h888, "mie_warl");
        irq_timer = 1'b1;
        tick();
        chk("irq_lat1", {31'b0, irq_pending}, 32'h0);
        tick();
        chk("irq_mti_pend", {31'b0, irq_pending}, 32'h1);
        chk("irq_mti_cause", irq_cause, 32'h8000_0007);
        irq_ext = 1'b1;
        tick();
        chk("irq_mei_lat1", irq_cause, 32'h8000_0007);
        tick();
        chk("irq_mei_cause", irq_cause, 32'h8000_000B);
        irq_soft = 1'b1; irq_ext = 1'b0;
        tick(); tick();
        chk("irq_msi_cause", irq_cause, 32'h8000_0003);
        rd(12'h344, 32'h088, "mip");
        wr(2'b01, 12'h300, 32'h0);
        chk("irq_masked", {31'b0, irq_pending}, 32'h0);

        // mtvec MODE WARL
        wr(2'b01, 12'h305, 32'h203);
        rd(12'h305, 32'h200, "mtvec_mode3");
        wr(2'b01, 12'h305, 32'h201);
        rd(12'h305, 32'h201, "mtvec_mode1");
        wr(2'b01, 12'h305, 32'h302);
        rd(12'h305, 32'h301, "mtvec_mode2");
        chk("mtvec_out", mtvec_out, 32'h301);

        // Asynchronous reset mid-run
        wr(2'b01, 12'h300, 32'h8);
        chk("pend_before_rst", {31'b0, irq_pending}, 32'h1);
        #2;
        rst_n = 1'b0;
        csr_addr = 12'h300; csr_op = 2'b10; csr_src_zero = 1'b1;
        #1;
        chk("rst_mid_mstatus", csr_rdata, 32'h0000_1800);
        chk("rst_mid_pending", {31'b0, irq_pending}, 32'h0);
        chk("rst_mid_cause", irq_cause, 32'h0);
        csr_addr = 12'hB00;
        #1;
        chk("rst_mid_mcycle", csr_rdata, 32'h0);
        csr_addr = 12'hB02;
        #1;
        chk("rst_mid_minstret", csr_rdata, 32'h0);
        chk("rst_mid_mtvec", mtvec_out, 32'h0);
        chk("rst_mid_mepc", mepc_out, 32'h0);
        csr_op = 2'b00; csr_src_zero = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
